psum_acc_relu: RTL and testbench
================================

// Module: psum_acc_relu
// PURPOSE
//  Downstream consumer of the 36-tap inner-product stage. Accepts NUM_PSUM signed partial sums
//  per output pixel, accumulates them at full width, adds a per-pixel bias, rescales with an
//  arithmetic right shift, applies ReLU, saturates, and presents one DATA_LEN result on a
//  valid/ready output. Sits between the inner-product stage and the feature-map writeback.
// PARAMETERS
//  DATA_LEN  `data_len  width of psums, bias and output (signed two's complement)
//  ACC_LEN   32         accumulator width; must be >= DATA_LEN+clog2(NUM_PSUM+1)+1
//  NUM_PSUM  4          partial sums per output pixel (>=1)
//  SHIFT     8          right shift applied after bias add (0..ACC_LEN-2)
// PORTS
//  clk        in   1         rising-edge clock
//  rst        in   1         asynchronous, active-high reset
//  flush      in   1         synchronous abort of current group and held output
//  in_valid   in   1         in_data valid
//  in_ready   out  1         block accepts in_data this cycle
//  in_data    in   DATA_LEN  signed partial sum
//  bias       in   DATA_LEN  signed bias; sampled in POST cycle, must be stable over the group
//  out_valid  out  1         out_data valid
//  out_ready  in   1         downstream accepts out_data
//  out_data   out  DATA_LEN  result
//  busy       out  1         high when cnt!=0 or state!=ACC
// BEHAVIOUR
//  - Reset: state=ACC, cnt=0, acc=0, out_valid=0, out_data=0, in_ready=1, busy=0.
//  - FSM states ACC, POST, HOLD.
//  - ACC: in_ready=1. Beat = in_valid&in_ready: acc<=acc+sext(in_data), cnt<=cnt+1.
//    On the beat with cnt==NUM_PSUM-1: cnt<=0, state<=POST (acc holds the full sum).
//  - POST (1 cycle): in_ready=0. s = acc + sext(bias); r = s >>> SHIFT (arithmetic, floor);
//    out_data <= clamp(r), out_valid<=1, acc<=0, state<=HOLD.
//  - HOLD: in_ready=0; out_data stable. out_valid&out_ready -> out_valid<=0, state<=ACC.
//  - Latency: last psum accepted at edge E0 -> out_valid high after E1. Min period NUM_PSUM+2.
//  - Clamp range: see CONFIGURATION. Saturation acts on r at ACC_LEN width, never wraps.
//  - Accumulator never overflows given the ACC_LEN rule; no saturation inside accumulation.
//  - in_valid while in_ready=0: ignored, no state change; upstream must hold data.
//  - flush (any state): next edge state=ACC, cnt=0, acc=0, out_valid=0; in_data on the
//    same cycle is not accepted. flush has priority over every other event.
//  - rst mid-group or mid-HOLD: partial sums and held result discarded immediately.
//  - out_ready while out_valid=0: no effect.
// CONFIGURATION
//  - PSUM_RELU_EN defined: clamp to [0, 2^(DATA_LEN-1)-1]; negative r -> 0.
//  - PSUM_RELU_EN undefined: signed clamp to [-2^(DATA_LEN-1), 2^(DATA_LEN-1)-1].
// TESTING (DATA_LEN=16, NUM_PSUM=4, SHIFT=4 unless noted)
//  1 psums 100,200,300,400 back-to-back, bias=16 -> out_data=63 (1016>>>4), out_valid 2 edges
//    after last beat, held until out_ready.
//  2 psums -1000 x4, bias=0 -> out_data=0 with PSUM_RELU_EN; -250 (16'hFF06) without.
//  3 SHIFT=0 instance: psums 32767 x4, bias=0 -> 32767; psums -32768 x4 without
//    PSUM_RELU_EN -> -32768 (saturated, not wrapped).
//  4 out_ready low 5 cycles after out_valid: out_data stable, in_ready=0, offered psums ignored;
//    out_ready high -> out_valid drops next edge, in_ready=1, next group of 1,2,3,4 bias 0 -> 0.
//  5 two psums (500,500), rst pulse, then psums 16,16,16,16 bias 0 -> out_data=4 (no residue).
//  6 three psums then flush with in_valid high -> beat not taken; psums 32 x4 bias 0 -> 8.

Source files
------------

// File: rtl/psum_acc_relu.sv
// Partial-sum accumulator: sums NUM_PSUM signed psums, adds bias, arithmetic-shifts, clamps.
// Optional macro PSUM_RELU_EN selects a ReLU clamp [0, max] instead of the signed clamp.
`ifndef PSUM_DATA_LEN
`define PSUM_DATA_LEN 16
`endif

module psum_acc_relu #(
  parameter int DATA_LEN = `PSUM_DATA_LEN,
  parameter int ACC_LEN  = 32,
  parameter int NUM_PSUM = 4,
  parameter int SHIFT    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_LEN-1:0] in_data,
  input  logic [DATA_LEN-1:0] bias,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_LEN-1:0] out_data,
  output logic                busy
);

  localparam int CNT_W = (NUM_PSUM > 1) ? $clog2(NUM_PSUM) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_PSUM - 1);

  localparam logic signed [ACC_LEN-1:0] SAT_MAX =
    {{(ACC_LEN-DATA_LEN+1){1'b0}}, {(DATA_LEN-1){1'b1}}};
`ifdef PSUM_RELU_EN
  localparam logic signed [ACC_LEN-1:0] SAT_MIN = '0;
`else
  localparam logic signed [ACC_LEN-1:0] SAT_MIN =
    {{(ACC_LEN-DATA_LEN+1){1'b1}}, {(DATA_LEN-1){1'b0}}};
`endif

  typedef enum logic [1:0] {ST_ACC, ST_POST, ST_HOLD} state_t;

  state_t                     state;
  logic [CNT_W-1:0]           cnt;
  logic signed [ACC_LEN-1:0]  acc;
  logic signed [ACC_LEN-1:0]  sum_b;
  logic signed [ACC_LEN-1:0]  shifted;
  logic [DATA_LEN-1:0]        clamped;
  logic                       beat;

  // flush must block the handshake in the same cycle so upstream keeps its data
  assign in_ready = (state == ST_ACC) && !flush;
  assign beat     = in_valid && in_ready;
  assign busy     = (cnt != '0) || (state != ST_ACC);

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    sum_b   = acc + {{(ACC_LEN-DATA_LEN){bias[DATA_LEN-1]}}, bias};
    shifted = sum_b >>> SHIFT;
    clamped = shifted[DATA_LEN-1:0];
    if (shifted > SAT_MAX)
      clamped = SAT_MAX[DATA_LEN-1:0];
    else if (shifted < SAT_MIN)
      clamped = SAT_MIN[DATA_LEN-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_ACC;
      cnt       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      state     <= ST_ACC;
      cnt       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_ACC: begin
          if (beat) begin
            acc <= acc + {{(ACC_LEN-DATA_LEN){in_data[DATA_LEN-1]}}, in_data};
            if (cnt == CNT_LAST) begin
              cnt   <= '0;
              state <= ST_POST;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        ST_POST: begin
          out_data  <= clamped;
          out_valid <= 1'b1;
          acc       <= '0;
          state     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_ACC;
          end
        end
        default: state <= ST_ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_acc_relu.sv
// Bench for psum_acc_relu: SHIFT=4 and SHIFT=0 instances share stimulus; a group-level
// model predicts every output each cycle, and literal expectations pin the model.
`timescale 1ns/1ps

module tb_psum_acc_relu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic [15:0] bias = '0;
  logic        out_ready = 1'b0;

  logic        in_ready_a, out_valid_a, busy_a;
  logic [15:0] out_data_a;
  logic        in_ready_b, out_valid_b, busy_b;
  logic [15:0] out_data_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  psum_acc_relu #(.DATA_LEN(16), .ACC_LEN(32), .NUM_PSUM(4), .SHIFT(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .bias(bias), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_data(out_data_a), .busy(busy_a));

  psum_acc_relu #(.DATA_LEN(16), .ACC_LEN(32), .NUM_PSUM(4), .SHIFT(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .bias(bias), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_data(out_data_b), .busy(busy_b));

  task automatic check(input string name, input longint actual, input longint expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Result of one complete group: floor shift, then clamp to the output range.
  function automatic longint ref_out(input longint s, input int sh);
    longint r;
    r = s >>> sh;
    if (r > 32767) r = 32767;
`ifdef PSUM_RELU_EN
    if (r < 0) r = 0;
`else
    if (r < -32768) r = -32768;
`endif
    return r;
  endfunction

  // Group-level model: psums taken so far, running sum, and the result being offered.
  int     m_taken;
  longint m_sum;
  bit     m_post;
  bit     m_hold;
  longint m_res_a, m_res_b;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_taken = 0; m_sum = 0; m_post = 0; m_hold = 0; m_res_a = 0; m_res_b = 0;
    end else if (flush) begin
      m_taken = 0; m_sum = 0; m_post = 0; m_hold = 0;
    end else if (m_post) begin
      m_res_a = ref_out(m_sum + longint'($signed(bias)), 4);
      m_res_b = ref_out(m_sum + longint'($signed(bias)), 0);
      m_sum   = 0;
      m_post  = 0;
      m_hold  = 1;
    end else if (m_hold) begin
      if (out_ready) m_hold = 0;
    end else if (in_valid) begin
      m_sum += longint'($signed(in_data));
      m_taken++;
      if (m_taken == 4) begin
        m_taken = 0;
        m_post  = 1;
      end
    end
  end

  always @(negedge clk) begin
    automatic bit exp_ready = !m_post && !m_hold && !flush;
    automatic bit exp_busy  = (m_taken != 0) || m_post || m_hold;
    check("in_ready_a", in_ready_a, exp_ready);
    check("in_ready_b", in_ready_b, exp_ready);
    check("out_valid_a", out_valid_a, m_hold);
    check("out_valid_b", out_valid_b, m_hold);
    check("busy_a", busy_a, exp_busy);
    check("busy_b", busy_b, exp_busy);
    if (m_hold) begin
      check("out_data_a", $signed(out_data_a), m_res_a);
      check("out_data_b", $signed(out_data_b), m_res_b);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input int v);
    in_valid = 1'b1;
    in_data  = 16'(v);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_group(input int v0, input int v1, input int v2, input int v3,
                            input int b);
    bias = 16'(b);
    send(v0); send(v1); send(v2); send(v3);
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (!out_valid_a && n < 10) begin
      tick();
      n++;
    end
    if (!out_valid_a) check("wait_out_valid", 0, 1);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #2;
    check("rst_out_valid", out_valid_a, 0);
    check("rst_in_ready", in_ready_a, 1);
    check("rst_busy", busy_a, 0);
    check("rst_out_data", out_data_a, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // 1: 1016 >>> 4 = 63, result appears one edge after the POST edge
    send_group(100, 200, 300, 400, 16);
    check("t1_valid_e0", out_valid_a, 0);
    check("t1_busy_e0", busy_a, 1);
    tick();
    check("t1_valid_e1", out_valid_a, 1);
    check("t1_data_a", $signed(out_data_a), 63);
    check("t1_data_b", $signed(out_data_b), 1016);
    tick(); tick();
    check("t1_held", $signed(out_data_a), 63);
    consume();
    check("t1_drop", out_valid_a, 0);
    check("t1_ready", in_ready_a, 1);

    // 2: negative group
    send_group(-1000, -1000, -1000, -1000, 0);
    wait_out();
`ifdef PSUM_RELU_EN
    check("t2_data_a", $signed(out_data_a), 0);
    check("t2_data_b", $signed(out_data_b), 0);
`else
    check("t2_data_a", out_data_a, 16'hFF06);
    check("t2_data_b", $signed(out_data_b), -4000);
`endif
    consume();

    // 3: saturation, most visible on the SHIFT=0 instance
    send_group(32767, 32767, 32767, 32767, 0);
    wait_out();
    check("t3_pos_b", $signed(out_data_b), 32767);
    check("t3_pos_a", $signed(out_data_a), 8191);
    consume();
    send_group(-32768, -32768, -32768, -32768, 0);
    wait_out();
`ifdef PSUM_RELU_EN
    check("t3_neg_b", $signed(out_data_b), 0);
`else
    check("t3_neg_b", $signed(out_data_b), -32768);
    check("t3_neg_a", $signed(out_data_a), -8192);
`endif
    consume();

    // 4: backpressure; psums offered during HOLD must be ignored
    send_group(1000, 1000, 1000, 1000, 0);
    wait_out();
    in_valid = 1'b1;
    in_data  = 16'd7777;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_hold_data", $signed(out_data_a), 250);
      check("t4_hold_ready", in_ready_a, 0);
    end
    in_valid = 1'b0;
    consume();
    check("t4_drop", out_valid_a, 0);
    check("t4_ready", in_ready_a, 1);
    send_group(1, 2, 3, 4, 0);
    wait_out();
    check("t4_next_a", $signed(out_data_a), 0);
    check("t4_next_b", $signed(out_data_b), 10);
    consume();

    // 5: reset mid-group discards partial sums
    send(500); send(500);
    rst = 1'b1;
    #1;
    check("t5_rst_busy", busy_a, 0);
    tick();
    rst = 1'b0;
    tick();
    send_group(16, 16, 16, 16, 0);
    wait_out();
    check("t5_data_a", $signed(out_data_a), 4);
    check("t5_data_b", $signed(out_data_b), 64);
    consume();

    // 6: flush with in_valid high is not a beat
    send(5); send(6); send(7);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'd99;
    #1;
    check("t6_flush_ready", in_ready_a, 0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("t6_flush_busy", busy_a, 0);
    send_group(32, 32, 32, 32, 0);
    wait_out();
    check("t6_data_a", $signed(out_data_a), 8);
    check("t6_data_b", $signed(out_data_b), 128);

    // flush also drops a held result
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t6_flush_hold", out_valid_a, 0);
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
